// File: rtl/atm_keypad_entry.sv
// ATM keypad session controller: card/PIN/operation/amount entry,
// downstream request handshake, retry lockout and inactivity timeout.
module atm_keypad_entry #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_TRIES      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        card_in,
  input  logic [3:0]  card_acc,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [2:0]  operation,
  output logic [15:0] amount,
  input  logic        resp_valid,
  input  logic        resp_ok,
  output logic        lockout,
  output logic        timeout,
  output logic [2:0]  state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TRY_MAX = TW'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PIN    = 3'd1,
    S_OP     = 3'd2,
    S_AMOUNT = 3'd3,
    S_SEND   = 3'd4,
    S_WAIT   = 3'd5,
    S_LOCKED = 3'd6
  } st_t;

  st_t st, st_n;

  logic [3:0]    acc_n;
  logic [15:0]   pin_n, amt_n;
  logic [2:0]    op_n;
  logic [2:0]    pcnt, pcnt_n;
  logic [2:0]    acnt, acnt_n;
  logic [TW-1:0] tries, tries_n, tries_inc;
  logic [CW-1:0] icnt, icnt_n;
  logic          to_n;
  logic          active;
  logic          k_dig, k_ent, k_can;

  assign k_dig     = key_code <= 4'd9;
  assign k_ent     = key_code == 4'hA;
  assign k_can     = key_code == 4'hB;
  assign tries_inc = tries + TW'(1);
  assign active    = st == S_PIN || st == S_OP || st == S_AMOUNT;

  assign state     = st;
  assign req_valid = st == S_SEND;
  assign lockout   = st == S_LOCKED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      acc_num   <= '0;
      pin       <= '0;
      operation <= '0;
      amount    <= '0;
      pcnt      <= '0;
      acnt      <= '0;
      tries     <= '0;
      icnt      <= '0;
      timeout   <= 1'b0;
    end else begin
      st        <= st_n;
      acc_num   <= acc_n;
      pin       <= pin_n;
      operation <= op_n;
      amount    <= amt_n;
      pcnt      <= pcnt_n;
      acnt      <= acnt_n;
      tries     <= tries_n;
      icnt      <= icnt_n;
      timeout   <= to_n;
    end
  end

  always_comb begin
    st_n    = st;
    acc_n   = acc_num;
    pin_n   = pin;
    op_n    = operation;
    amt_n   = amount;
    pcnt_n  = pcnt;
    acnt_n  = acnt;
    tries_n = tries;
    to_n    = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (card_in) begin
          acc_n   = card_acc;
          pin_n   = '0;
          pcnt_n  = '0;
          op_n    = '0;
          amt_n   = '0;
          acnt_n  = '0;
          tries_n = '0;
          st_n    = S_PIN;
        end
      end
      S_PIN, S_OP, S_AMOUNT: begin
        if (!card_in) begin
          st_n = S_IDLE;
        end else if (key_valid) begin
          if (st == S_PIN) begin
            unique case (1'b1)
              k_dig: begin
                case (pcnt)
                  3'd0: pin_n[15:12] = key_code;
                  3'd1: pin_n[11:8]  = key_code;
                  3'd2: pin_n[7:4]   = key_code;
                  3'd3: pin_n[3:0]   = key_code;
                  default: ;
                endcase
                if (pcnt < 3'd4) pcnt_n = pcnt + 3'd1;
              end
              k_ent: if (pcnt == 3'd4) st_n = S_OP;
              k_can: st_n = S_IDLE;
              default: ;
            endcase
          end else if (st == S_OP) begin
            unique case (1'b1)
              k_dig: begin
                case (key_code)
                  4'd1, 4'd4, 4'd2, 4'd3: begin
                    op_n   = key_code[2:0];
                    amt_n  = '0;
                    acnt_n = '0;
                    st_n   = (key_code == 4'd2 || key_code == 4'd3)
                             ? S_AMOUNT : S_SEND;
                  end
                  4'd5: st_n = S_IDLE;
                  default: ;
                endcase
              end
              k_can: st_n = S_IDLE;
              default: ;
            endcase
          end else begin
            unique case (1'b1)
              k_dig: begin
                if (acnt < 3'd4) begin
                  amt_n  = amount * 16'd10 + {12'd0, key_code};
                  acnt_n = acnt + 3'd1;
                end
              end
              k_ent: if (amount != 16'd0) st_n = S_SEND;
              k_can: begin
                amt_n  = '0;
                acnt_n = '0;
                st_n   = S_OP;
              end
              default: ;
            endcase
          end
        end else if (icnt == TO_LAST) begin
          to_n = 1'b1;
          st_n = S_IDLE;
        end
      end
      S_SEND: if (req_ready) st_n = S_WAIT;
      S_WAIT: begin
        // A card pulled during the transaction is honoured only here
        if (resp_valid) begin
          if (resp_ok) begin
            tries_n = '0;
            st_n    = card_in ? S_OP : S_IDLE;
          end else begin
            tries_n = tries_inc;
            if (tries_inc == TRY_MAX) begin
              st_n = S_LOCKED;
            end else begin
              pin_n  = '0;
              pcnt_n = '0;
              st_n   = card_in ? S_PIN : S_IDLE;
            end
          end
        end
      end
      S_LOCKED: if (!card_in) st_n = S_IDLE;
      default: st_n = S_IDLE;
    endcase
  end

  always_comb begin
    icnt_n = '0;
    if (st_n == st && !key_valid && active) icnt_n = icnt + CW'(1);
  end

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed bench for atm_keypad_entry: session flow, handshake,
// lockout, timeout, amount limits and asynchronous reset.
module tb_atm_keypad_entry;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        card_in;
  logic [3:0]  card_acc;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [2:0]  operation;
  logic [15:0] amount;
  logic        resp_valid;
  logic        resp_ok;
  logic        lockout;
  logic        timeout;
  logic [2:0]  state;

  int checks = 0;
  int fails  = 0;

  atm_keypad_entry #(.TIMEOUT_CYCLES(TO), .MAX_TRIES(3)) dut (
    .clk(clk), .rst_n(rst_n), .card_in(card_in), .card_acc(card_acc),
    .key_valid(key_valid), .key_code(key_code), .req_valid(req_valid),
    .req_ready(req_ready), .acc_num(acc_num), .pin(pin),
    .operation(operation), .amount(amount), .resp_valid(resp_valid),
    .resp_ok(resp_ok), .lockout(lockout), .timeout(timeout),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    cyc(1);
    key_valid = 1'b0;
  endtask

  task automatic start(input logic [3:0] acc);
    card_in = 1'b0;
    cyc(2);
    card_in  = 1'b1;
    card_acc = acc;
    cyc(1);
  endtask

  task automatic enter_pin(input logic [15:0] p);
    press(p[15:12]);
    press(p[11:8]);
    press(p[7:4]);
    press(p[3:0]);
    press(4'hA);
  endtask

  task automatic chk_st(input string nm, input logic [2:0] exp);
    checks++;
    if (state !== exp) begin
      fails++;
      $display("FAIL %s: state=%0d expected=%0d", nm, state, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state, req_valid, lockout, timeout, acc_num, pin, operation, amount}
        !== '0) begin
      fails++;
      $display("FAIL reset_zero: st=%0d rv=%b lk=%b to=%b acc=%h pin=%h op=%0d amt=%0d",
               state, req_valid, lockout, timeout, acc_num, pin, operation, amount);
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    card_in = 0; card_acc = 0; key_valid = 0; key_code = 0;
    req_ready = 0; resp_valid = 0; resp_ok = 0;
    rst_n = 1'b0;
    cyc(2);
    checks++;
    if ({state, req_valid, lockout, timeout, pin, amount} !== '0) begin
      fails++;
      $display("FAIL reset_state: st=%0d pin=%h amt=%0d", state, pin, amount);
    end
    rst_n = 1'b1;
    cyc(2);
    chk_st("idle_no_card", 3'd0);
  endtask

  task automatic test_main_flow();
    start(4'd7);
    chk_st("enter_pin_state", 3'd1);
    enter_pin(16'h1234);
    chk_st("pin_to_op", 3'd2);
    press(4'd2);
    chk_st("op_to_amount", 3'd3);
    press(4'd5);
    press(4'd0);
    press(4'hA);
    checks++;
    if ({req_valid, acc_num, pin, operation, amount}
        !== {1'b1, 4'd7, 16'h1234, 3'd2, 16'd50}) begin
      fails++;
      $display("FAIL main_req: rv=%b acc=%0d pin=%h op=%0d amt=%0d expected 1 7 1234 2 50",
               req_valid, acc_num, pin, operation, amount);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 4) card_in = 1'b0;
      cyc(1);
      checks++;
      if ({state, req_valid, acc_num, pin, operation, amount}
          !== {3'd4, 1'b1, 4'd7, 16'h1234, 3'd2, 16'd50}) begin
        fails++;
        $display("FAIL send_hold[%0d]: st=%0d rv=%b pin=%h amt=%0d",
                 i, state, req_valid, pin, amount);
      end
    end
    req_ready = 1'b1;
    cyc(1);
    req_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b0) begin
      fails++;
      $display("FAIL accept_drop: req_valid=%b expected=0", req_valid);
    end
    cyc(3);
    chk_st("card_out_wait_deferred", 3'd5);
    resp_valid = 1'b1; resp_ok = 1'b1;
    cyc(1);
    resp_valid = 1'b0;
    chk_st("card_out_after_resp", 3'd0);
  endtask

  task automatic test_pin_entry();
    start(4'd3);
    press(4'd1); press(4'd2); press(4'd3);
    press(4'hA);
    chk_st("short_pin_enter", 3'd1);
    checks++;
    if (pin !== 16'h1230) begin
      fails++;
      $display("FAIL pin_partial: pin=%h expected=1230", pin);
    end
    press(4'd4);
    press(4'd5);
    press(4'hC);
    checks++;
    if (pin !== 16'h1234) begin
      fails++;
      $display("FAIL pin_fifth: pin=%h expected=1234", pin);
    end
    press(4'hA);
    chk_st("pin_enter_full", 3'd2);
    press(4'hB);
    chk_st("op_cancel", 3'd0);
  endtask

  task automatic test_card_pull();
    start(4'd2);
    card_in   = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'd8;
    cyc(1);
    key_valid = 1'b0;
    chk_st("pull_priority", 3'd0);
    checks++;
    if (pin !== 16'h0) begin
      fails++;
      $display("FAIL pull_key_ignored: pin=%h expected=0000", pin);
    end
  endtask

  task automatic test_lockout();
    start(4'd9);
    for (int t = 0; t < 3; t++) begin
      enter_pin(16'h9999);
      press(4'd1);
      req_ready = 1'b1;
      cyc(1);
      req_ready  = 1'b0;
      resp_valid = 1'b1; resp_ok = 1'b0;
      cyc(1);
      resp_valid = 1'b0;
      if (t < 2) begin
        checks++;
        if (state !== 3'd1 || pin !== 16'h0) begin
          fails++;
          $display("FAIL retry[%0d]: st=%0d pin=%h expected 1 0000", t, state, pin);
        end
      end
    end
    checks++;
    if (state !== 3'd6 || lockout !== 1'b1) begin
      fails++;
      $display("FAIL locked: st=%0d lockout=%b expected 6 1", state, lockout);
    end
    press(4'd1);
    chk_st("locked_key_ignored", 3'd6);
    card_in = 1'b0;
    cyc(1);
    checks++;
    if (state !== 3'd0 || lockout !== 1'b0) begin
      fails++;
      $display("FAIL unlock: st=%0d lockout=%b expected 0 0", state, lockout);
    end
  endtask

  task automatic test_back_to_back();
    start(4'd5);
    enter_pin(16'h4321);
    press(4'd1);
    req_ready = 1'b1;
    cyc(1);
    req_ready  = 1'b0;
    resp_valid = 1'b1; resp_ok = 1'b1;
    cyc(1);
    resp_valid = 1'b0;
    chk_st("ok_to_op", 3'd2);
    press(4'd4);
    checks++;
    if ({state, req_valid, operation, amount, pin}
        !== {3'd4, 1'b1, 3'd4, 16'd0, 16'h4321}) begin
      fails++;
      $display("FAIL second_req: st=%0d rv=%b op=%0d amt=%0d pin=%h",
               state, req_valid, operation, amount, pin);
    end
    #2;
    do_reset();
    checks++;
    if (req_valid !== 1'b0) begin
      fails++;
      $display("FAIL send_reset: req_valid=%b expected=0", req_valid);
    end
  endtask

  task automatic test_timeout();
    start(4'd1);
    enter_pin(16'h1111);
    cyc(TO - 1);
    checks++;
    if (state !== 3'd2 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL pre_timeout: st=%0d to=%b expected 2 0", state, timeout);
    end
    cyc(1);
    checks++;
    if (state !== 3'd0 || timeout !== 1'b1) begin
      fails++;
      $display("FAIL timeout_pulse: st=%0d to=%b expected 0 1", state, timeout);
    end
    cyc(1);
    checks++;
    if (timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout_one_cycle: to=%b expected=0", timeout);
    end
  endtask

  task automatic test_amount();
    start(4'd4);
    enter_pin(16'h5678);
    press(4'd3);
    for (int i = 0; i < 5; i++) press(4'd9);
    checks++;
    if (amount !== 16'd9999 || operation !== 3'd3) begin
      fails++;
      $display("FAIL amount_max: amt=%0d op=%0d expected 9999 3", amount, operation);
    end
    press(4'hB);
    chk_st("amount_cancel", 3'd2);
    press(4'd2);
    press(4'd0);
    press(4'hA);
    chk_st("zero_enter_ignored", 3'd3);
    press(4'd7);
    checks++;
    if (amount !== 16'd7) begin
      fails++;
      $display("FAIL amount_restart: amt=%0d expected=7", amount);
    end
    #2;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_main_flow();
    test_pin_entry();
    test_card_pull();
    test_lockout();
    test_back_to_back();
    test_timeout();
    test_amount();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/atm_keypad_entry.md
ATM_KEYPAD_ENTRY -- requirements
Module: atm_keypad_entry

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000: idle-key cycles before a session aborts.
REQ-002 SHALL have parameter MAX_TRIES, default 3: failed PIN responses before lockout.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 card_in  in  1  card-present level.
REQ-007 card_acc  in  4  account number from card reader, valid while card_in=1.
REQ-008 key_valid  in  1  one-cycle keypad strobe.
REQ-009 key_code  in  4  0-9 digit, 4'hA ENTER, 4'hB CANCEL, 4'hC-4'hF ignored.
REQ-010 req_valid  out  1  request to downstream ATM stage.
REQ-011 req_ready  in  1  downstream accepts the request.
REQ-012 acc_num  out  4  latched account number.
REQ-013 pin  out  16  four BCD digits, first entered in [15:12].
REQ-014 operation  out  3  1 balance, 2 withdraw, 3 deposit, 4 change PIN.
REQ-015 amount  out  16  binary amount, 0 unless operation is 2 or 3.
REQ-016 resp_valid  in  1  one-cycle downstream response strobe.
REQ-017 resp_ok  in  1  with resp_valid: 1 authenticated/complete, 0 PIN rejected.
REQ-018 lockout  out  1  card locked.
REQ-019 timeout  out  1  one-cycle pulse on session timeout.
REQ-020 state  out  3  current state code.

Function
REQ-021 States and codes SHALL be: IDLE 0, PIN 1, OP 2, AMOUNT 3, SEND 4, WAIT 5, LOCKED 6.
REQ-022 IDLE: card_in=1 SHALL latch card_acc into acc_num, clear pin/amount/try count, and enter PIN next cycle.
REQ-023 PIN: each digit SHALL shift into pin, left-justified, with a digit count 0-4; digits after the fourth SHALL be ignored.
REQ-024 PIN: ENTER with count=4 SHALL go to OP; ENTER with count<4 SHALL be ignored.
REQ-025 OP: digit 1 or 4 SHALL set operation and go to SEND; 2 or 3 SHALL set operation, clear amount, and go to AMOUNT; 5 SHALL go to IDLE; other digits SHALL be ignored.
REQ-026 AMOUNT: each digit SHALL update amount = amount*10 + digit, for at most 4 digits (max 9999); further digits SHALL be ignored.
REQ-027 AMOUNT: ENTER with amount>0 SHALL go to SEND; ENTER with amount=0 SHALL be ignored.
REQ-028 CANCEL SHALL go from AMOUNT to OP, and from PIN or OP to IDLE.
REQ-029 SEND: req_valid=1 SHALL be held, with acc_num/pin/operation/amount stable, until the cycle req_ready=1; the next state SHALL be WAIT.
REQ-030 WAIT: resp_valid with resp_ok=1 SHALL clear the try count and go to OP.
REQ-031 WAIT: resp_valid with resp_ok=0 SHALL increment the try count; at MAX_TRIES go to LOCKED, else go to PIN with pin and count cleared.
REQ-032 LOCKED: lockout SHALL be 1; card_in=0 SHALL go to IDLE; keys SHALL be ignored.
REQ-033 card_in=0 in PIN/OP/AMOUNT SHALL go to IDLE next cycle, taking priority over a same-cycle key.
REQ-034 card_in=0 in SEND/WAIT SHALL be deferred until the handshake/response completes, then go to IDLE.
REQ-035 The inactivity counter SHALL clear on key_valid or a state change.
REQ-036 The inactivity counter SHALL count only in PIN/OP/AMOUNT; reaching TIMEOUT_CYCLES-1 SHALL pulse timeout and go to IDLE.
REQ-037 key_valid outside PIN/OP/AMOUNT SHALL be ignored.

Reset
REQ-038 rst_n=0 SHALL immediately force IDLE and set req_valid=0, lockout=0, timeout=0, acc_num=0, pin=0, operation=0, amount=0, try count=0, and inactivity counter=0.
REQ-039 Reset asserted in SEND SHALL drop req_valid asynchronously.

Verification
REQ-040 card_in=1, card_acc=7; keys 1,2,3,4,ENTER,2,5,0,ENTER -> req_valid=1, acc_num=7, pin=16'h1234, operation=2, amount=50; held until req_ready.
REQ-041 Three resp_valid/resp_ok=0 after PIN entries -> state LOCKED, lockout=1; card_in=0 -> IDLE, lockout=0.
REQ-042 Keys 1,2,3,ENTER -> remains PIN; 5th digit after 1,2,3,4 ignored, pin=16'h1234.
REQ-043 req_ready held 0 for 10 cycles in SEND -> req_valid and outputs stable throughout; card_in=0 mid-SEND -> IDLE only after accept and response.
REQ-044 No key for TIMEOUT_CYCLES in OP -> one-cycle timeout pulse, state IDLE.
REQ-045 Amount keys 9,9,9,9,9 -> amount=9999; CANCEL -> OP; reset mid-AMOUNT -> all outputs zero.
